bus_arbiter: RTL

//  Two-master arbiter sharing the single data-side system bus (DM + TC0/TC1 via the bridge).

---
 rtl/bus_arbiter_pkg.sv | 22 ++
 rtl/arb_hold_counter.sv | 28 ++
 rtl/bus_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the two-master data-bus arbiter.
// The grant states are encoded so their value doubles as the one-hot owner.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_GNT0 = 2'b01,
      ARB_GNT1 = 2'b10
   } arb_state_t;

   localparam int MAX_HOLD_DEF = 8;
   localparam int HOLD_W_DEF   = 4;

   function automatic logic [1:0] owner_of(input arb_state_t s);
      case (s)
         ARB_GNT0: return 2'b01;
         ARB_GNT1: return 2'b10;
         default:  return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// Saturating count of granted cycles during which the other master was waiting.
// limit is raised once the count reaches MAX_HOLD-1, which forces the lock to yield.
module arb_hold_counter #(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic limit
);

   localparam logic [HOLD_W-1:0] LIMIT_VAL = HOLD_W'(MAX_HOLD - 1);

   logic [HOLD_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != LIMIT_VAL)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign limit = (cnt == LIMIT_VAL);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter giving one of two masters the shared data-side bus,
// with optional lock bounded by MAX_HOLD cycles while the other master waits.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int HOLD_W   = HOLD_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_byteen,
   input  logic        m0_lock,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_byteen,
   input  logic        m1_lock,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_byteen,
   input  logic [31:0] bus_rdata,
   output logic [1:0]  owner
);

   arb_state_t state, state_nxt;
   logic       last_owner;
   logic       hold_limit;
   logic       hold_clr;
   logic       hold_inc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE: begin
            if (m0_req && m1_req) state_nxt = last_owner ? ARB_GNT0 : ARB_GNT1;
            else if (m0_req)      state_nxt = ARB_GNT0;
            else if (m1_req)      state_nxt = ARB_GNT1;
            else                  state_nxt = ARB_IDLE;
         end
         ARB_GNT0: begin
            if (m0_req && m0_lock && !(m1_req && hold_limit)) state_nxt = ARB_GNT0;
            else if (m1_req)                                  state_nxt = ARB_GNT1;
            else if (m0_req)                                  state_nxt = ARB_GNT0;
            else                                              state_nxt = ARB_IDLE;
         end
         ARB_GNT1: begin
            if (m1_req && m1_lock && !(m0_req && hold_limit)) state_nxt = ARB_GNT1;
            else if (m0_req)                                  state_nxt = ARB_GNT0;
            else if (m1_req)                                  state_nxt = ARB_GNT1;
            else                                              state_nxt = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // Fairness pointer follows whoever actually completed a transfer last.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_owner <= 1'b1;
      end else if ((state == ARB_GNT0) && m0_req) begin
         last_owner <= 1'b0;
      end else if ((state == ARB_GNT1) && m1_req) begin
         last_owner <= 1'b1;
      end
   end

   assign hold_clr = (state == ARB_IDLE) || (state_nxt != state);
   assign hold_inc = ((state == ARB_GNT0) && m1_req) || ((state == ARB_GNT1) && m0_req);

   arb_hold_counter #(
      .MAX_HOLD (MAX_HOLD),
      .HOLD_W   (HOLD_W)
   ) u_hold (
      .clk   (clk),
      .reset (reset),
      .clr   (hold_clr),
      .inc   (hold_inc),
      .limit (hold_limit)
   );

   // Byte enables are gated by req so an owner that withdraws cannot write.
   always_comb begin
      bus_addr   = '0;
      bus_wdata  = '0;
      bus_byteen = '0;
      m0_ack     = 1'b0;
      m1_ack     = 1'b0;
      case (state)
         ARB_GNT0: begin
            bus_addr   = m0_addr;
            bus_wdata  = m0_wdata;
            bus_byteen = m0_req ? m0_byteen : 4'h0;
            m0_ack     = m0_req;
         end
         ARB_GNT1: begin
            bus_addr   = m1_addr;
            bus_wdata  = m1_wdata;
            bus_byteen = m1_req ? m1_byteen : 4'h0;
            m1_ack     = m1_req;
         end
         default: begin
            bus_addr   = '0;
         end
      endcase
   end

   assign m0_rdata = m0_ack ? bus_rdata : 32'h0;
   assign m1_rdata = m1_ack ? bus_rdata : 32'h0;
   assign owner    = owner_of(state);

endmodule
